// File: rtl/secuenciador_cuentas.sv
// rtl/secuenciador_cuentas.sv - timed 4-phase sequencer feeding the 4:1 count mux select and terminal-count flags
module secuenciador_cuentas #(
  parameter int ANCHO = 8,
  parameter int T0    = 3,
  parameter int T1    = 2,
  parameter int T2    = 1,
  parameter int T3    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             habilitar,
  input  logic             tick,
  input  logic             reinicio_sync,
  output logic [1:0]       Seleccion,
  output logic [ANCHO-1:0] cuenta,
  output logic             D0,
  output logic             D1,
  output logic             D2,
  output logic             D3,
  output logic             fin_ciclo
);

  typedef enum logic [1:0] {F0 = 2'd0, F1 = 2'd1, F2 = 2'd2, F3 = 2'd3} fase_t;

  // A zero duration behaves as a single-tick phase.
  localparam int E0 = (T0 == 0) ? 1 : T0;
  localparam int E1 = (T1 == 0) ? 1 : T1;
  localparam int E2 = (T2 == 0) ? 1 : T2;
  localparam int E3 = (T3 == 0) ? 1 : T3;

  localparam logic [ANCHO-1:0] C0  = ANCHO'(E0 - 1);
  localparam logic [ANCHO-1:0] C1  = ANCHO'(E1 - 1);
  localparam logic [ANCHO-1:0] C2  = ANCHO'(E2 - 1);
  localparam logic [ANCHO-1:0] C3  = ANCHO'(E3 - 1);
  localparam logic [ANCHO-1:0] UNO = ANCHO'(1);

  if ((T0 > 2**ANCHO) || (T1 > 2**ANCHO) || (T2 > 2**ANCHO) || (T3 > 2**ANCHO)) begin : g_duracion_invalida
    $error("secuenciador_cuentas: phase duration exceeds 2**ANCHO");
  end

  function automatic logic [ANCHO-1:0] carga(input fase_t f);
    case (f)
      F0:      carga = C0;
      F1:      carga = C1;
      F2:      carga = C2;
      default: carga = C3;
    endcase
  endfunction

  fase_t      fase;
  logic [3:0] pulsos;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fase      <= F0;
      cuenta    <= C0;
      pulsos    <= 4'b0000;
      fin_ciclo <= 1'b0;
    end else if (reinicio_sync) begin
      fase      <= F0;
      cuenta    <= C0;
      pulsos    <= 4'b0000;
      fin_ciclo <= 1'b0;
    end else if (habilitar && tick) begin
      if (cuenta != '0) begin
        cuenta    <= cuenta - UNO;
        pulsos    <= 4'b0000;
        fin_ciclo <= 1'b0;
      end else begin
        // Last tick of the phase: flag the phase being left and load the next one.
        fase      <= fase_t'(fase + 2'd1);
        cuenta    <= carga(fase_t'(fase + 2'd1));
        pulsos    <= 4'b0001 << fase;
        fin_ciclo <= (fase == F3);
      end
    end else begin
      pulsos    <= 4'b0000;
      fin_ciclo <= 1'b0;
    end
  end

  assign Seleccion = fase;
  assign D0 = pulsos[0];
  assign D1 = pulsos[1];
  assign D2 = pulsos[2];
  assign D3 = pulsos[3];

endmodule
